// File: rtl/sevenseg_scan_driver_if.sv
// Display-side bundle for the seven-segment scan driver.
// The host drives value/control; the driver returns segment and anode pins.
interface sevenseg_scan_driver_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic                    en;
  logic [4*NUM_DIGITS-1:0] value;
  logic                    load;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic                    blank_lz;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_done;

  modport master (
    output en, value, load, dp_mask, blank_lz,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  en, value, load, dp_mask, blank_lz,
    output seg, dp, an, frame_done
  );
endinterface

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed hex seven-segment driver with frame-synchronous
// double buffering, leading-zero blanking and per-digit decimal points.
module sevenseg_scan_driver #(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned REFRESH_DIV    = 100000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  sevenseg_scan_driver_if.slave bus
);

  localparam int unsigned IW =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned PW =
    (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned VW = 4 * NUM_DIGITS;

  localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [6:0] SEG_INV = {7{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_INV =
    {NUM_DIGITS{AN_ACTIVE_LOW}};

  logic [PW-1:0]         presc;
  logic [IW-1:0]         idx;
  logic [VW-1:0]         active;
  logic [VW-1:0]         pending;
  logic                  pend_valid;
  logic                  tc;
  logic                  wrap;
  logic                  fd_q;
  logic [NUM_DIGITS-1:0] lz;
  logic                  nz_acc;
  logic [3:0]            nib;
  logic                  blank;
  logic [6:0]            seg_hi;
  logic [NUM_DIGITS-1:0] an_hi;
  logic [NUM_DIGITS-1:0] an_q;
  logic [6:0]            seg_q;
  logic                  dp_q;

  assign tc   = bus.en && (presc == P_LAST);
  assign wrap = tc && (idx == I_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      idx   <= '0;
    end else if (bus.en) begin
      if (tc) begin
        presc <= '0;
        idx   <= wrap ? '0 : idx + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  // A load landing on the wrap cycle bypasses the pending slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active     <= '0;
      pending    <= '0;
      pend_valid <= 1'b0;
    end else if (wrap) begin
      if (bus.load) begin
        active <= bus.value;
      end else if (pend_valid) begin
        active <= pending;
      end
      pend_valid <= 1'b0;
    end else if (bus.load) begin
      pending    <= bus.value;
      pend_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fd_q <= 1'b0;
    end else begin
      fd_q <= wrap;
    end
  end

  // lz[i] is set when nibbles i..top are all zero.
  always_comb begin
    lz     = '0;
    nz_acc = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nz_acc = nz_acc | (|active[4*i +: 4]);
      lz[i]  = !nz_acc;
    end
  end

  assign nib   = 4'(active >> {idx, 2'b00});
  assign blank = bus.blank_lz && (idx != '0) && lz[idx];
  assign an_hi = NUM_DIGITS'(1) << idx;

  always_comb begin
    unique case (nib)
      4'h0: seg_hi = 7'b1111110;
      4'h1: seg_hi = 7'b0110000;
      4'h2: seg_hi = 7'b1101101;
      4'h3: seg_hi = 7'b1111001;
      4'h4: seg_hi = 7'b0110011;
      4'h5: seg_hi = 7'b1011011;
      4'h6: seg_hi = 7'b1011111;
      4'h7: seg_hi = 7'b1110000;
      4'h8: seg_hi = 7'b1111111;
      4'h9: seg_hi = 7'b1111011;
      4'hA: seg_hi = 7'b1110111;
      4'hB: seg_hi = 7'b0011111;
      4'hC: seg_hi = 7'b1001110;
      4'hD: seg_hi = 7'b0111101;
      4'hE: seg_hi = 7'b1001111;
      4'hF: seg_hi = 7'b1000111;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q  <= AN_INV;
      seg_q <= SEG_INV;
      dp_q  <= SEG_ACTIVE_LOW;
    end else if (!bus.en || blank) begin
      an_q  <= AN_INV;
      seg_q <= SEG_INV;
      dp_q  <= SEG_ACTIVE_LOW;
    end else begin
      an_q  <= an_hi ^ AN_INV;
      seg_q <= seg_hi ^ SEG_INV;
      dp_q  <= bus.dp_mask[idx] ^ SEG_ACTIVE_LOW;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Bench for sevenseg_scan_driver: fixed scenarios, decode table and
// randomized traffic against a cycle-level reference model.
module tb_sevenseg_scan_driver;

  localparam int ND = 4;
  localparam int RD = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  sevenseg_scan_driver_if #(.NUM_DIGITS(ND)) tif ();

  sevenseg_scan_driver #(
    .NUM_DIGITS(ND),
    .REFRESH_DIV(RD),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(tif)
  );

  // Reference model: hex table in active-high form, state as integers.
  logic [6:0] hex_tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  int          m_presc;
  int          m_idx;
  logic [15:0] m_act;
  logic [15:0] m_pend;
  logic        m_pv;
  logic [3:0]  m_an;
  logic [6:0]  m_seg;
  logic        m_dp;
  logic        m_fd;
  logic        m_wrap;

  function automatic int digit_of(logic [15:0] v, int d);
    return int'((v >> (4 * d)) & 16'hF);
  endfunction

  function automatic bit is_blank(logic [15:0] v, int d, logic blz);
    return blz && d > 0 && ((v >> (4 * d)) == 16'h0);
  endfunction

  assign m_wrap = tif.en && m_presc == RD - 1 && m_idx == ND - 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_presc <= 0;
      m_idx   <= 0;
      m_act   <= '0;
      m_pend  <= '0;
      m_pv    <= 1'b0;
      m_an    <= 4'hF;
      m_seg   <= 7'h7F;
      m_dp    <= 1'b1;
      m_fd    <= 1'b0;
    end else begin
      if (!tif.en || is_blank(m_act, m_idx, tif.blank_lz)) begin
        m_an  <= 4'hF;
        m_seg <= 7'h7F;
        m_dp  <= 1'b1;
      end else begin
        m_an  <= ~(4'b0001 << m_idx);
        m_seg <= ~hex_tab[digit_of(m_act, m_idx)];
        m_dp  <= ~tif.dp_mask[m_idx];
      end
      m_fd <= m_wrap;
      if (m_wrap) begin
        m_act <= tif.load ? tif.value : (m_pv ? m_pend : m_act);
        m_pv  <= 1'b0;
      end else if (tif.load) begin
        m_pend <= tif.value;
        m_pv   <= 1'b1;
      end
      if (tif.en) begin
        if (m_presc == RD - 1) begin
          m_presc <= 0;
          m_idx   <= (m_idx + 1) % ND;
        end else begin
          m_presc <= m_presc + 1;
        end
      end
    end
  end

  typedef struct {
    logic [3:0] nib;
    logic [6:0] seg;
  } dvec_t;

  dvec_t dv [16];

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    chk("model", {tif.an, tif.seg, tif.dp, tif.frame_done},
        {m_an, m_seg, m_dp, m_fd});
  endtask

  task automatic wait_fd(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (tif.frame_done !== 1'b1 && n < 64);
    if (tif.frame_done !== 1'b1) begin
      bad++;
      total++;
      $display("FAIL wait_fd: got timeout expected frame_done");
    end
  endtask

  task automatic frame_check(string nm, logic [15:0] an_e,
                             logic [27:0] seg_e);
    int d;
    for (int k = 1; k <= 13; k++) begin
      step();
      if (k % 4 == 1) begin
        d = k / 4;
        chk($sformatf("%s_an%0d", nm, d), tif.an, an_e[4*d +: 4]);
        chk($sformatf("%s_seg%0d", nm, d), tif.seg, seg_e[7*d +: 7]);
      end
    end
  endtask

  task automatic pulse_load(logic [15:0] v);
    tif.value = v;
    tif.load  = 1'b1;
    step();
    tif.load  = 1'b0;
  endtask

  task automatic chk_dark(string nm);
    chk({nm, "_an"}, tif.an, 4'hF);
    chk({nm, "_seg"}, tif.seg, 7'h7F);
    chk({nm, "_dp"}, tif.dp, 1'b1);
    chk({nm, "_fd"}, tif.frame_done, 1'b0);
  endtask

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] SOFF = 7'h7F;

  initial begin
    int n;
    logic [15:0] v;
    dv[0]  = '{4'h0, 7'b0000001};
    dv[1]  = '{4'h1, 7'b1001111};
    dv[2]  = '{4'h2, 7'b0010010};
    dv[3]  = '{4'h3, 7'b0000110};
    dv[4]  = '{4'h4, 7'b1001100};
    dv[5]  = '{4'h5, 7'b0100100};
    dv[6]  = '{4'h6, 7'b0100000};
    dv[7]  = '{4'h7, 7'b0001111};
    dv[8]  = '{4'h8, 7'b0000000};
    dv[9]  = '{4'h9, 7'b0000100};
    dv[10] = '{4'hA, 7'b0001000};
    dv[11] = '{4'hB, 7'b1100000};
    dv[12] = '{4'hC, 7'b0110001};
    dv[13] = '{4'hD, 7'b1000010};
    dv[14] = '{4'hE, 7'b0110000};
    dv[15] = '{4'hF, 7'b0111000};

    tif.en       = 1'b0;
    tif.value    = '0;
    tif.load     = 1'b0;
    tif.dp_mask  = '0;
    tif.blank_lz = 1'b0;
    #1 rst = 1'b1;
    #1 chk_dark("reset");
    repeat (2) step();
    #2 rst = 1'b0;

    // Idle scan of an all-zero buffer
    tif.en = 1'b1;
    wait_fd(n);
    frame_check("zero", 16'h7BDE, {4{S0}});
    wait_fd(n);
    chk("fd_period", 13 + n, 16);

    // Mid-frame load appears only after the next wrap
    repeat (5) step();
    pulse_load(16'h12AF);
    step();
    chk("hold_old", tif.seg, S0);
    wait_fd(n);
    frame_check("hex", 16'h7BDE,
      {7'b1001111, 7'b0010010, 7'b0001000, 7'b0111000});

    // Last load in a frame wins; a wrap-cycle load is taken at once
    step();
    pulse_load(16'h1111);
    pulse_load(16'h2222);
    wait_fd(n);
    step();
    chk("two_loads", tif.seg, 7'b0010010);
    repeat (14) step();
    tif.value = 16'h3333;
    tif.load  = 1'b1;
    step();
    tif.load  = 1'b0;
    chk("wrap_fd", tif.frame_done, 1'b1);
    step();
    chk("wrap_load", tif.seg, 7'b0000110);

    // Leading-zero blanking
    tif.blank_lz = 1'b1;
    pulse_load(16'h0050);
    wait_fd(n);
    frame_check("blank", 16'hFFDE, {SOFF, SOFF, 7'b0100100, S0});
    pulse_load(16'h0000);
    wait_fd(n);
    frame_check("blank0", 16'hFFFE, {SOFF, SOFF, SOFF, S0});
    tif.blank_lz = 1'b0;

    // Decimal point follows the lit digit
    tif.dp_mask = 4'b0100;
    pulse_load(16'h12AF);
    wait_fd(n);
    for (int k = 1; k <= 13; k++) begin
      step();
      if (k % 4 == 1)
        chk($sformatf("dp%0d", k / 4), tif.dp, (k == 9) ? 1'b0 : 1'b1);
    end
    tif.dp_mask = '0;

    // Scan enable pause mid-digit resumes with the remaining count
    wait_fd(n);
    repeat (6) step();
    tif.en = 1'b0;
    step();
    chk("en_off", tif.an, 4'hF);
    repeat (9) step();
    tif.en = 1'b1;
    step();
    chk("resume1", tif.an, 4'b1101);
    step();
    chk("resume2", tif.an, 4'b1101);
    step();
    chk("resume3", tif.an, 4'b1011);

    // Asynchronous reset drops a pending load
    wait_fd(n);
    repeat (3) step();
    pulse_load(16'h4321);
    repeat (2) step();
    #2 rst = 1'b1;
    #1 chk_dark("async_rst");
    #3 rst = 1'b0;
    wait_fd(n);
    frame_check("post_rst", 16'h7BDE, {4{S0}});

    // Decode table on digit 0
    for (int i = 0; i < 16; i++) begin
      pulse_load({4{dv[i].nib}});
      wait_fd(n);
      step();
      chk($sformatf("dec_%h", dv[i].nib), tif.seg, dv[i].seg);
      chk($sformatf("dec_an_%h", dv[i].nib), tif.an, 4'b1110);
    end

    // Randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      v = 16'($urandom);
      for (int d = 0; d < ND; d++)
        if ($urandom_range(0, 2) == 0) v[4*d +: 4] = 4'h0;
      tif.en       = ($urandom_range(0, 9) != 0);
      tif.load     = ($urandom_range(0, 7) == 0);
      tif.value    = v;
      tif.dp_mask  = 4'($urandom);
      tif.blank_lz = 1'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_driver.md
Name: sevenseg_scan_driver

Overview:
- Parametrised, time-multiplexed seven-segment display driver for NUM_DIGITS common-anode digits.
- Decodes the full hex range 0-F, with optional leading-zero blanking and per-digit decimal points.
- Double-buffers the displayed value and swaps it only at a scan-frame boundary, so the display never tears.
- Sits between the ALU result/switch logic and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; legal range 1..8.
- REFRESH_DIV, 100000, clk cycles each digit stays lit; legal range >=1.
- SEG_ACTIVE_LOW, 1, 1 = seg/dp driven low-true; 0 = high-true.
- AN_ACTIVE_LOW, 1, 1 = anodes driven low-true; 0 = high-true.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-high.
- en  input  1  scan enable; low = display dark, scan counters hold.
- value  input  4*NUM_DIGITS  hex nibbles; nibble i (bits 4i+3:4i) drives digit i; digit 0 is rightmost.
- load  input  1  single-cycle strobe that captures value into the pending buffer.
- dp_mask  input  NUM_DIGITS  decimal point request per digit; sampled live, not buffered.
- blank_lz  input  1  enable leading-zero blanking.
- seg  output  7  segments {a,b,c,d,e,f,g}; seg[6]=a, seg[0]=g.
- dp  output  1  decimal point for the currently lit digit.
- an  output  NUM_DIGITS  anode enables, one-hot active while scanning.
- frame_done  output  1  one-cycle pulse at each scan wrap.

Behaviour:
- Reset: all of the following clear. Output values below are stated for the active-low default.
  - an = all inactive (all 1s); seg = all off (7'b1111111); dp = off (1); frame_done = 0.
  - Internal: prescaler = 0, digit index = 0, active buffer = 0, pending buffer = 0, pend_valid = 0.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 while en = 1.
  - At terminal count it returns to 0 and the index advances by 1, modulo NUM_DIGITS.
  - REFRESH_DIV = 1 advances the index every cycle.
- Wrap:
  - Defined as the terminal-count cycle with index = NUM_DIGITS-1.
  - NUM_DIGITS = 1: every terminal count is a wrap.
  - frame_done is registered and pulses high for the cycle after each wrap.
- Load/buffer handshake:
  - load=1 with no wrap: pending <= value, pend_valid <= 1.
  - At wrap with load=1 in the same cycle: active <= value directly; pend_valid <= 0.
  - At wrap with pend_valid=1: active <= pending; pend_valid <= 0.
  - At wrap otherwise: active holds.
  - Multiple loads within one frame: the last one wins.
  - load is honoured even while en=0; the swap waits for the next wrap.
- Decode:
  - Hex table, active-high segment form: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
  - Inverted on output when SEG_ACTIVE_LOW=1.
- Leading-zero blanking:
  - Digit i>0 is blanked when blank_lz=1 and active nibbles i..NUM_DIGITS-1 are all zero.
  - Digit 0 is never blanked.
  - A blanked digit has its anode inactive, seg off and dp off.
- Output registration:
  - an, seg and dp are registered one cycle after the index/active update.
  - Exactly one anode is active per cycle, except when the digit is blanked or en=0.
  - No glitch state: an and seg change in the same clock edge.
- en=0:
  - Next cycle: an = all inactive, seg = off, dp = off.
  - Prescaler and index hold their values; scanning resumes from those values on en=1.
  - frame_done is not generated while en=0.
- Reset mid-frame: a pending load is discarded, and the first frame after reset shows 0.

Test Plan:
- Use NUM_DIGITS=4, REFRESH_DIV=4 throughout.
- Reset then en=1, no load -> an cycles 1110, 1101, 1011, 0111 with 4 cycles each; seg=0000001 throughout; frame_done pulses every 16 cycles.
- load value=16'h12AF mid-frame -> display still shows 0000 until the next wrap; afterwards digit0 seg=0111000 (F), digit1=0001000 (A), digit2=0010010 (2), digit3=1001111 (1).
- Two loads in one frame (16'h1111, then 16'h2222); then load coinciding with the wrap cycle (16'h3333) -> 2222 shown after the first wrap; 3333 shown immediately after the wrap whose cycle coincided with its load.
- blank_lz=1 with value=16'h0050 -> digits 3 and 2 have anodes inactive; digit1 shows 5; digit0 shows 0. With value=16'h0000 only digit0 is lit.
- dp_mask=4'b0100 -> dp=0 only while an=1011.
- en deasserted for 10 cycles mid-digit -> an=1111 next cycle; on re-enable the same digit resumes with the remaining prescaler count.
- Async rst pulse mid-frame with pend_valid=1 -> outputs go dark immediately without waiting for clk; after release the display shows 0000 and the pending value is lost.
